game_turn_sched: RTL
====================

Name: game_turn_sched

Overview:
- Two-player turn scheduler for the timed sequence-matching memory game.
- Owns the game timer: loads the per-turn time budget, enables the countdown, and treats the timer's Stop (time expired) flag as a turn failure.
- Alternates turns between player 1 and player 2 and checks each player's key entries against a captured target sequence.
- Keeps both scores and declares a winner after a fixed number of rounds.

Parameters:
- SEQ_LEN, 4: digits per target sequence (1..8).
- DIG_W, 4: bits per digit.
- TURN_TIME, 9: value loaded into the timer at the start of each turn (4-bit).
- ROUNDS, 3: turns per player in one game (1..7).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  1-cycle pulse that begins a game; honoured only in IDLE or DONE.
- Seq_In  in  SEQ_LEN*DIG_W  target sequence, captured on an accepted Start; digit 0 sits in bits [DIG_W-1:0].
- Key_Valid  in  1  1-cycle strobe for a player key entry.
- Key_Val  in  DIG_W  value of the entered key.
- Tmr_Stop  in  1  timer-expired flag from the game timer (level).
- Tmr_Load  out  1  load strobe to the timer.
- Tmr_Val  out  4  load value; always equal to TURN_TIME.
- Tmr_En  out  1  countdown enable to the timer.
- Player  out  2  one-hot active player: 01 = P1, 10 = P2, 00 = none.
- Idx  out  3  index of the next expected digit.
- Turn_Ok  out  1  1-cycle pulse: turn passed.
- Turn_Fail  out  1  1-cycle pulse: turn failed.
- Score1, Score2  out  3 each  points won by each player.
- Game_Over  out  1  high while in DONE.
- Winner  out  2  01 = P1, 10 = P2, 11 = tie, 00 = game not finished.

Behaviour:
- Reset (Rst=0, asynchronous):
  - State goes to IDLE.
  - Every output is 0, except Tmr_Val, which is TURN_TIME.
  - Internal sequence register, turn counter and Idx clear to 0.
- States: IDLE, LOAD, PLAY, JUDGE, DONE.
- Outputs are Moore-decoded from registered state, except the Turn_Ok/Turn_Fail pulses, which are registered on entry to JUDGE.
- IDLE:
  - Player = 00.
  - On Start: capture Seq_In, clear both scores, clear the turn counter, select P1, go to LOAD.
- LOAD (exactly 1 cycle):
  - Tmr_Load = 1, Tmr_En = 0, Idx cleared to 0.
  - Always goes to PLAY.
- PLAY:
  - Tmr_En = 1.
  - Priority within a cycle: Tmr_Stop, then Key_Valid.
  - Tmr_Stop = 1 → fail, go to JUDGE. A key arriving in the same cycle is ignored.
  - Key_Valid with Key_Val equal to digit[Idx]:
    - If Idx = SEQ_LEN-1 → success, go to JUDGE.
    - Otherwise Idx increments by 1.
  - Key_Valid with a mismatching digit → fail, go to JUDGE.
  - Tmr_Stop is ignored outside PLAY (a stale level left from the previous turn is masked by LOAD).
- JUDGE (1 cycle):
  - Tmr_En = 0.
  - Exactly one of Turn_Ok or Turn_Fail pulses high.
  - On success, the active player's score increments (saturates at 7).
  - Turn counter increments.
  - If the counter reaches 2*ROUNDS → DONE.
  - Otherwise toggle Player → LOAD.
- DONE:
  - Player = 00, Game_Over = 1.
  - Winner: 01 if Score1 > Score2, 10 if Score2 > Score1, 11 if equal.
  - Scores are held.
  - Start → behaves as in IDLE (new game, scores cleared, Winner back to 00).
- Start outside IDLE/DONE is ignored.
- Key_Valid outside PLAY is ignored.
- Reset mid-turn aborts immediately to IDLE; no pulse is issued.
- Latency:
  - Start sampled at edge n → Tmr_Load high for cycle n+1 → PLAY from n+2.
  - A decisive key or Tmr_Stop at edge m → JUDGE pulse at m+1 → LOAD at m+2.

Test Plan (SEQ_LEN=4, DIG_W=4, TURN_TIME=9, ROUNDS=3):
- Reset release, Start with Seq_In=16'h3A71 → Tmr_Load=1 for one cycle, Tmr_Val=9, then Tmr_En=1 and Player=01.
- P1 keys 1,7,A,3 → Idx steps 0→1→2→3, Turn_Ok pulses, Score1=1, Player=10, Tmr_Load pulses again.
- P2 keys 1,5 → Turn_Fail after key 5, Score2=0, Player=01.
- P1 keys 1, then Tmr_Stop=1 in the same cycle as Key_Valid with value 7 → Turn_Fail, Score1 unchanged at 1.
- Play the full 6 turns with P1 passing 2 and P2 passing 2 → Game_Over=1, Winner=11. Start again → scores 0, Winner=00, Player=01.
- Assert Rst=0 in PLAY with Idx=2 → all outputs 0 (Tmr_Val=9), state IDLE. Start pulsed during PLAY → no effect.

Source files
------------

// File: rtl/game_turn_sched.sv
// Two-player turn scheduler for the timed sequence-matching memory game.
// Drives the game timer, checks each player's key entries against the
// captured target sequence, keeps both scores and declares the winner.
module game_turn_sched #(
  parameter int         SEQ_LEN   = 4,
  parameter int         DIG_W     = 4,
  parameter logic [3:0] TURN_TIME = 4'd9,
  parameter int         ROUNDS    = 3
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [SEQ_LEN*DIG_W-1:0] Seq_In,
  input  logic                     Key_Valid,
  input  logic [DIG_W-1:0]         Key_Val,
  input  logic                     Tmr_Stop,
  output logic                     Tmr_Load,
  output logic [3:0]               Tmr_Val,
  output logic                     Tmr_En,
  output logic [1:0]               Player,
  output logic [2:0]               Idx,
  output logic                     Turn_Ok,
  output logic                     Turn_Fail,
  output logic [2:0]               Score1,
  output logic [2:0]               Score2,
  output logic                     Game_Over,
  output logic [1:0]               Winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_JUDGE,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX  = 3'(SEQ_LEN - 1);
  localparam logic [3:0] LAST_TURN = 4'(2 * ROUNDS - 1);

  state_t                   state;
  state_t                   state_next;
  logic [SEQ_LEN*DIG_W-1:0] seq_reg;
  logic [3:0]               turn_cnt;
  logic [2:0]               idx_q;
  logic [1:0]               player_q;
  logic [2:0]               score1_q;
  logic [2:0]               score2_q;
  logic                     ok_q;
  logic                     fail_q;
  logic [DIG_W-1:0]         cur_digit;
  logic                     last_turn;
  logic                     start_game;
  logic                     key_hit;
  logic                     turn_pass;
  logic                     turn_fail;

  assign cur_digit = seq_reg[int'(idx_q)*DIG_W +: DIG_W];
  assign last_turn = (turn_cnt == LAST_TURN);

  // State register; reset aborts any turn in progress without a pulse
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state decode; within PLAY the timer expiry outranks any key strobe
  always_comb begin
    state_next = state;
    start_game = 1'b0;
    key_hit    = 1'b0;
    turn_pass  = 1'b0;
    turn_fail  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          start_game = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_PLAY;
      S_PLAY: begin
        if (Tmr_Stop) begin
          turn_fail  = 1'b1;
          state_next = S_JUDGE;
        end else if (Key_Valid) begin
          if (Key_Val == cur_digit) begin
            if (idx_q == LAST_IDX) begin
              turn_pass  = 1'b1;
              state_next = S_JUDGE;
            end else begin
              key_hit = 1'b1;
            end
          end else begin
            turn_fail  = 1'b1;
            state_next = S_JUDGE;
          end
        end
      end
      S_JUDGE: state_next = last_turn ? S_DONE : S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Game datapath: sequence capture, digit index, scores, turn count, player
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      seq_reg  <= '0;
      turn_cnt <= '0;
      idx_q    <= '0;
      player_q <= 2'b00;
      score1_q <= '0;
      score2_q <= '0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      ok_q   <= turn_pass;
      fail_q <= turn_fail;
      if (start_game) begin
        seq_reg  <= Seq_In;
        turn_cnt <= '0;
        idx_q    <= '0;
        player_q <= 2'b01;
        score1_q <= '0;
        score2_q <= '0;
      end
      if (key_hit) idx_q <= idx_q + 3'd1;
      if (state == S_JUDGE) begin
        turn_cnt <= turn_cnt + 4'd1;
        if (ok_q && player_q[0] && (score1_q != 3'd7)) score1_q <= score1_q + 3'd1;
        if (ok_q && player_q[1] && (score2_q != 3'd7)) score2_q <= score2_q + 3'd1;
        if (!last_turn) begin
          player_q <= {player_q[0], player_q[1]};
          idx_q    <= '0;
        end
      end
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    Winner = 2'b00;
    if (state == S_DONE) begin
      if (score1_q > score2_q)      Winner = 2'b01;
      else if (score2_q > score1_q) Winner = 2'b10;
      else                          Winner = 2'b11;
    end
  end

  assign Tmr_Load  = (state == S_LOAD);
  assign Tmr_Val   = TURN_TIME;
  assign Tmr_En    = (state == S_PLAY);
  assign Player    = (state == S_LOAD || state == S_PLAY || state == S_JUDGE) ? player_q : 2'b00;
  assign Idx       = idx_q;
  assign Turn_Ok   = ok_q;
  assign Turn_Fail = fail_q;
  assign Score1    = score1_q;
  assign Score2    = score2_q;
  assign Game_Over = (state == S_DONE);

endmodule
